// File: rtl/diag_pkg.sv
// Shared constants, parser states and helpers for the diag serial command path.
// Used by the command receiver top and its UART receive sub-module.
package diag_pkg;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] SP = 8'h20;

  typedef enum logic [2:0] {
    S_CHL,
    S_H2,
    S_H1,
    S_H0,
    S_TERM,
    S_SYNC
  } parse_state_t;

  function automatic int sym_cnt(input int clk_freq, input int sym_rate);
    return clk_freq / sym_rate;
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Letters share the low nybble layout of 'A'/'a' = x1, so add 9 for both cases.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    if (c <= 8'h39) return c[3:0];
    return c[3:0] + 4'd9;
  endfunction

endpackage

// File: rtl/acia_rx.sv
// UART 8N1 receiver: 2-FF synchronizer, start-bit mid-sample, LSB-first data, stop check.
// rx_stb/rx_ferr pulse one cycle at mid stop bit; no backpressure, the consumer must take every byte.
module acia_rx #(
  parameter int SCW     = 9,
  parameter int sym_cnt = 416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_dat,
  output logic       rx_stb,
  output logic       rx_ferr
);

  typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} rx_state_t;

  localparam logic [SCW-1:0] HALF = SCW'(sym_cnt / 2);
  localparam logic [SCW-1:0] FULL = SCW'(sym_cnt - 1);

  rx_state_t      state_q, state_d;
  logic           meta_q, meta_d;
  logic           sync_q, sync_d;
  logic           prev_q, prev_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           stb_q, stb_d;
  logic           ferr_q, ferr_d;

  always_comb begin
    meta_d  = rx_serial;
    sync_d  = meta_q;
    prev_d  = sync_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    stb_d   = 1'b0;
    ferr_d  = 1'b0;

    if ((state_q == START || state_q == DATA || state_q == STOP) && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;

    case (state_q)
      // A line held low out of reset must go idle before a start bit is accepted.
      ARM: if (sync_q) state_d = IDLE;
      IDLE: begin
        if (prev_q && !sync_q) begin
          cnt_d   = HALF;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (sync_q) begin
            state_d = IDLE;
          end else begin
            cnt_d   = FULL;
            bit_d   = 3'd0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync_q, shift_q[7:1]};
          cnt_d   = FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (sync_q) begin
            stb_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ARM;
          end
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= ARM;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      stb_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stb_q   <= stb_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_dat  = shift_q;
  assign rx_stb  = stb_q;
  assign rx_ferr = ferr_q;

endmodule

// File: rtl/diag_cmd_rx.sv
// Parses "<chl> <hhh><CR|LF>" lines from the UART into four 12-bit diag registers.
// Register, wr_chl and wr_stb update one clock after the terminator strobe; input cannot be stalled.
module diag_cmd_rx
  import diag_pkg::*;
#(
  parameter int CLK_FREQ = 48000000,
  parameter int SYM_RATE = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [11:0] d0,
  output logic [11:0] d1,
  output logic [11:0] d2,
  output logic [11:0] d3,
  output logic        wr_stb,
  output logic [1:0]  wr_chl,
  output logic        err
);

  localparam int SYM_CNT = sym_cnt(CLK_FREQ, SYM_RATE);
  localparam int SCW     = $clog2(SYM_CNT);

  logic [7:0] rx_dat;
  logic       rx_stb;
  logic       rx_ferr;

  acia_rx #(
    .SCW     (SCW),
    .sym_cnt (SYM_CNT)
  ) u_acia_rx (
    .clk       (clk),
    .rst       (reset),
    .rx_serial (rx),
    .rx_dat    (rx_dat),
    .rx_stb    (rx_stb),
    .rx_ferr   (rx_ferr)
  );

  parse_state_t state_q, state_d;
  logic [1:0]   chl_q, chl_d;
  logic [11:0]  acc_q, acc_d;
  logic [11:0]  d_q [4];
  logic [11:0]  d_d [4];
  logic         wr_stb_q, wr_stb_d;
  logic [1:0]   wr_chl_q, wr_chl_d;
  logic         err_q, err_d;

  logic is_term;
  logic is_sp;
  logic is_chl;

  assign is_term = (rx_dat == CR) || (rx_dat == LF);
  assign is_sp   = (rx_dat == SP);
  assign is_chl  = (rx_dat >= 8'h30) && (rx_dat <= 8'h33);

  always_comb begin
    state_d  = state_q;
    chl_d    = chl_q;
    acc_d    = acc_q;
    d_d      = d_q;
    wr_stb_d = 1'b0;
    wr_chl_d = wr_chl_q;
    err_d    = 1'b0;

    if (rx_ferr) begin
      state_d = S_SYNC;
      err_d   = 1'b1;
    end else if (rx_stb) begin
      if (state_q == S_SYNC) begin
        if (is_term) state_d = S_CHL;
      end else if (!is_sp) begin
        case (state_q)
          // Bare terminators here absorb CRLF pairs and blank lines.
          S_CHL: begin
            if (is_chl) begin
              chl_d   = rx_dat[1:0];
              state_d = S_H2;
            end else if (!is_term) begin
              state_d = S_SYNC;
              err_d   = 1'b1;
            end
          end
          S_H2, S_H1, S_H0: begin
            if (is_hex(rx_dat)) begin
              acc_d   = {acc_q[7:0], hex_val(rx_dat)};
              state_d = (state_q == S_H2) ? S_H1 :
                        (state_q == S_H1) ? S_H0 : S_TERM;
            end else if (is_term) begin
              state_d = S_CHL;
              err_d   = 1'b1;
            end else begin
              state_d = S_SYNC;
              err_d   = 1'b1;
            end
          end
          S_TERM: begin
            if (is_term) begin
              d_d[chl_q] = acc_q;
              wr_chl_d   = chl_q;
              wr_stb_d   = 1'b1;
              state_d    = S_CHL;
            end else begin
              state_d = S_SYNC;
              err_d   = 1'b1;
            end
          end
          default: state_d = S_CHL;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_CHL;
      chl_q    <= 2'd0;
      acc_q    <= 12'h000;
      d_q      <= '{default: 12'h000};
      wr_stb_q <= 1'b0;
      wr_chl_q <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chl_q    <= chl_d;
      acc_q    <= acc_d;
      d_q      <= d_d;
      wr_stb_q <= wr_stb_d;
      wr_chl_q <= wr_chl_d;
      err_q    <= err_d;
    end
  end

  assign d0     = d_q[0];
  assign d1     = d_q[1];
  assign d2     = d_q[2];
  assign d3     = d_q[3];
  assign wr_stb = wr_stb_q;
  assign wr_chl = wr_chl_q;
  assign err    = err_q;

endmodule

// File: doc/diag_cmd_rx.md
Name: diag_cmd_rx

Overview:
Serial diagnostic command receiver, the receive-side counterpart of the diag serial hex dump. It accepts ASCII lines over a 115200-8N1 UART. Each line sets one of four 12-bit diagnostic registers, for example "2 A5F<CR>" loads register 2 with 0xA5F. It sits beside the diag transmitter and drives trim/test values into the datapath from a host terminal.

Parameters:
CLK_FREQ, 48000000, system clock frequency in Hz
SYM_RATE, 115200, UART bit rate; SYM_CNT = CLK_FREQ/SYM_RATE (416), SCW = $clog2(SYM_CNT)

Ports:
clk  input  1  system clock, 48 MHz
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial input, idle high
d0  output  12  diagnostic register 0
d1  output  12  diagnostic register 1
d2  output  12  diagnostic register 2
d3  output  12  diagnostic register 3
wr_stb  output  1  one-cycle pulse when a register is written
wr_chl  output  2  index of the last written register
err  output  1  one-cycle pulse on a framing or parse error

Behaviour:
- Reset values: d0..d3=0x000, wr_stb=0, wr_chl=0, err=0. Parser goes to S_CHL; receiver goes to ARM.
- Reset mid-byte or mid-line: all partial state is discarded and no register is written.
- Receiver input: rx passes through a 2-FF synchronizer.
- Receiver ARM: waits for synced rx=1, so a line held low at reset is not taken as a start bit.
- Receiver IDLE: a falling edge of synced rx loads the bit counter with SYM_CNT/2.
- Receiver START: at mid-bit the start bit is resampled. If it is 1, it was a glitch: return to IDLE silently.
- Receiver DATA: 8 bits sampled every SYM_CNT clocks, LSB first.
- Receiver STOP: sample the stop bit. If 1, pulse rx_stb for 1 cycle with rx_dat. If 0, pulse rx_ferr and go to ARM.
- Parser FSM states: S_CHL, S_H2, S_H1, S_H0, S_TERM, S_SYNC. Parser acts only on rx_stb.
- Space (0x20) is ignored in every state except S_SYNC.
- S_CHL: '0'..'3' latches chl and goes to S_H2. CR/LF is ignored, which tolerates CRLF and blank lines. Any other byte goes to S_SYNC.
- S_H2/S_H1/S_H0: a hex digit ('0'-'9', 'A'-'F', 'a'-'f') is shifted into a 12-bit accumulator, MSB nybble first, then the FSM advances. CR/LF here is an error and goes to S_CHL with no write. Any other byte goes to S_SYNC.
- S_TERM: CR/LF writes d[chl] <= acc, wr_chl <= chl, pulses wr_stb, then goes to S_CHL. Any other byte goes to S_SYNC; a 4th hex digit counts as "other".
- S_SYNC: discards bytes until CR/LF, then goes to S_CHL.
- err pulses for 1 cycle on every transition into S_SYNC, on an early terminator, and on rx_ferr.
- rx_ferr forces the parser to S_SYNC regardless of state.
- Latency: d[chl], wr_chl and wr_stb update on the clock edge after the rx_stb cycle of the terminator byte.
- Registers d0..d3 hold their value indefinitely. Only the addressed register changes.
- Simultaneous rx_stb and rx_ferr cannot occur, since they are mutually exclusive by construction.

Decomposition:
- Shared package diag_pkg holds:
  - ASCII constants: CR=8'h0D, LF=8'h0A, SP=8'h20.
  - Parser state enum.
  - Function sym_cnt(clk_freq, sym_rate).
- One sub-module, acia_rx, covers the synchronizer, the receiver FSM and the bit counter.
  - Ports: clk, rst, rx_serial, rx_dat[7:0], rx_stb, rx_ferr.
  - Parameters: SCW, sym_cnt.
  - It mirrors the existing acia_tx.
- diag_cmd_rx itself is the parser plus the register file.

Test Plan:
- Send "2 A5F\r" at 115200 (bit period 416 clk) -> d2=0xA5F, wr_chl=2, exactly one wr_stb pulse, d0/d1/d3 remain 0x000, err never asserts.
- Send "0fff\r\n" then "3 012\n" -> d0=0xFFF, then d3=0x012. Two wr_stb pulses total; the trailing LF is ignored with no err.
- Send "1 G00\r" then "1 123\r" -> err pulses once on 'G', no write for the first line; d1=0x123 after the second line.
- Send "2 AB\r" then "2 ABCD\r" -> the early CR gives err with no write. The 5th character 'D' gives err and S_SYNC until CR; d2 is unchanged.
- Send a byte with stop bit forced 0 in the middle of "3 456\r", then send "3 789\r" -> err pulse, first line dropped, d3=0x789.
- Hold rx low through reset and 1000 clk after, then release and send "0 001\r" -> no spurious byte or err; d0=0x001. Asserting reset mid-line leaves all d=0 and no wr_stb.
